// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the ID/EX stage state encoding.
package cpu_types_pkg;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;

  typedef enum logic [1:0] {RUN, HOLD, BUBBLE} id_ex_state_t;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the ID instruction and a load sitting in EX.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     id_valid,
  input  regbits_t id_rs1,
  input  regbits_t id_rs2,
  input  logic     id_uses_rs2,
  input  logic     ex_valid,
  input  logic     ex_MemRead,
  input  regbits_t ex_rd,
  output logic     load_use
);
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rs1_hit  = (ex_rd == id_rs1);
  assign rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
  assign load_use = id_valid && ex_valid && ex_MemRead && (ex_rd != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure hold and branch flush.
module id_ex_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   id_valid,
  input  regbits_t               id_rs1,
  input  regbits_t               id_rs2,
  input  logic                   id_uses_rs2,
  input  regbits_t               id_rd,
  input  logic                   id_RegWr,
  input  logic                   id_MemRead,
  input  logic                   id_MemWrite,
  input  aluop_t                 id_aluop,
  input  word_t                  id_rdat1,
  input  word_t                  id_rdat2,
  input  word_t                  id_imm,
  input  word_t                  id_pc,
  input  logic                   ex_ready,
  input  logic                   flush,
  output logic                   id_stall,
  output logic                   ex_valid,
  output regbits_t               ex_rs1,
  output regbits_t               ex_rs2,
  output regbits_t               ex_rd,
  output logic                   ex_RegWr,
  output logic                   ex_MemRead,
  output logic                   ex_MemWrite,
  output aluop_t                 ex_aluop,
  output word_t                  ex_rdat1,
  output word_t                  ex_rdat2,
  output word_t                  ex_imm,
  output word_t                  ex_pc,
  output logic [STALL_CNT_W-1:0] bubble_cnt
);
  id_ex_state_t state;
  logic         load_use;
  logic         hold;

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_MemRead  (ex_MemRead),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign hold     = ~ex_ready;
  assign id_stall = ~flush & (hold | load_use);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= RUN;
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_RegWr    <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_aluop    <= '0;
      ex_rdat1    <= '0;
      ex_rdat2    <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      state       <= RUN;
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_RegWr    <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
    end else if (hold) begin
      state <= HOLD;
    end else if (load_use) begin
      // Bubble clears everything forwarding looks at; operand data is left as-is
      state       <= BUBBLE;
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_RegWr    <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      if (bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      state       <= RUN;
      ex_valid    <= id_valid;
      ex_rs1      <= id_valid ? id_rs1 : '0;
      ex_rs2      <= id_valid ? id_rs2 : '0;
      ex_rd       <= id_valid ? id_rd  : '0;
      ex_RegWr    <= id_valid & id_RegWr;
      ex_MemRead  <= id_valid & id_MemRead;
      ex_MemWrite <= id_valid & id_MemWrite;
      ex_aluop    <= id_aluop;
      ex_rdat1    <= id_rdat1;
      ex_rdat2    <= id_rdat2;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
    end
  end

  // A slot left behind by a bubble must never look like a live write or load
  always_ff @(posedge CLK) begin
    if (nRST && state == BUBBLE)
      assert (!ex_valid && !ex_RegWr && !ex_MemRead && !ex_MemWrite);
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubbles, hold, flush and counter saturation.
module tb_id_ex_stage;
  import cpu_types_pkg::*;

  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         id_valid, id_uses_rs2, id_RegWr, id_MemRead, id_MemWrite;
  regbits_t     id_rs1, id_rs2, id_rd;
  aluop_t       id_aluop;
  word_t        id_rdat1, id_rdat2, id_imm, id_pc;
  logic         ex_ready, flush;
  logic         id_stall, ex_valid, ex_RegWr, ex_MemRead, ex_MemWrite;
  regbits_t     ex_rs1, ex_rs2, ex_rd;
  aluop_t       ex_aluop;
  word_t        ex_rdat1, ex_rdat2, ex_imm, ex_pc;
  logic [W-1:0] bubble_cnt;

  int tests  = 0;
  int failed = 0;

  id_ex_stage #(.STALL_CNT_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_RegWr(id_RegWr), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_aluop(id_aluop), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_pc(id_pc),
    .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWr(ex_RegWr),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_aluop(ex_aluop),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic v, input regbits_t rs1, input regbits_t rs2, input logic u2,
                        input regbits_t rd, input logic rw, input logic mr, input logic mw,
                        input aluop_t op, input word_t d1);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs2 = u2;
    id_rd       = rd;
    id_RegWr    = rw;
    id_MemRead  = mr;
    id_MemWrite = mw;
    id_aluop    = op;
    id_rdat1    = d1;
    id_rdat2    = d1 + 32'd1;
    id_imm      = d1 + 32'd2;
    id_pc       = d1 + 32'd3;
  endtask

  initial begin
    ex_ready = 1'b1;
    flush    = 1'b0;
    nRST     = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0, 32'h55);

    // reset with a valid instruction waiting in ID
    tick; tick;
    check("rst_valid", ex_valid, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_memread", ex_MemRead, 0);
    check("rst_rdat1", ex_rdat1, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_stall", id_stall, 0);

    // lw x5 then dependent add on rs1
    nRST = 1'b1;
    tick;
    check("lw_valid", ex_valid, 1);
    check("lw_rd", ex_rd, 5);
    check("lw_memread", ex_MemRead, 1);
    check("lw_pc", ex_pc, 32'h58);
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'h1, 32'h22);
    #1;
    check("lu_rs1_stall", id_stall, 1);
    tick;
    check("bub_valid", ex_valid, 0);
    check("bub_regwr", ex_RegWr, 0);
    check("bub_rd", ex_rd, 0);
    check("bub_keep_data", ex_rdat1, 32'h55);
    check("bub_cnt", bubble_cnt, 1);
    check("bub_stall_clear", id_stall, 0);
    tick;
    check("add_valid", ex_valid, 1);
    check("add_rd", ex_rd, 6);
    check("add_rs1", ex_rs1, 5);
    check("add_rdat1", ex_rdat1, 32'h22);
    check("add_aluop", ex_aluop, 4'h1);

    // rs2 match ignored when rs2 is not an operand
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0, 32'h55);
    tick;
    set_id(1'b1, 5'd3, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 4'h1, 32'h77);
    #1;
    check("no_rs2_stall", id_stall, 0);
    tick;
    check("no_rs2_rd", ex_rd, 7);
    check("no_rs2_valid", ex_valid, 1);

    // load to x0 never hazards
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h66);
    tick;
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 4'h1, 32'h88);
    #1;
    check("x0_stall", id_stall, 0);
    tick;
    check("x0_rd", ex_rd, 8);

    // real rs2 dependency
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0, 32'h55);
    tick;
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'h2, 32'h33);
    #1;
    check("lu_rs2_stall", id_stall, 1);
    tick;
    check("rs2_bub_valid", ex_valid, 0);
    check("rs2_bub_cnt", bubble_cnt, 2);
    tick;
    check("rs2_add_rd", ex_rd, 9);

    // EX back-pressure for three cycles
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 4'h3, 32'h44);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", id_stall, 1);
      tick;
      check("hold_rd", ex_rd, 9);
      check("hold_rdat1", ex_rdat1, 32'h33);
      check("hold_cnt", bubble_cnt, 2);
    end
    ex_ready = 1'b1;
    #1;
    check("release_stall", id_stall, 0);
    tick;
    check("release_rd", ex_rd, 10);
    check("release_aluop", ex_aluop, 4'h3);

    // hazard persists through hold and is counted once after release
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0, 32'h55);
    tick;
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'h1, 32'h22);
    ex_ready = 1'b0;
    tick; tick;
    check("hlu_rd", ex_rd, 5);
    check("hlu_cnt", bubble_cnt, 2);
    ex_ready = 1'b1;
    #1;
    check("hlu_stall", id_stall, 1);
    tick;
    check("hlu_bub_valid", ex_valid, 0);
    check("hlu_bub_cnt", bubble_cnt, 3);
    tick;
    check("hlu_add_rd", ex_rd, 6);

    // flush beats hold and load-use
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0, 32'h55);
    tick;
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'h1, 32'h22);
    ex_ready = 1'b0;
    flush    = 1'b1;
    #1;
    check("flush_stall", id_stall, 0);
    tick;
    check("flush_valid", ex_valid, 0);
    check("flush_regwr", ex_RegWr, 0);
    check("flush_memread", ex_MemRead, 0);
    check("flush_rd", ex_rd, 0);
    check("flush_cnt", bubble_cnt, 3);
    flush    = 1'b0;
    ex_ready = 1'b1;
    tick;
    check("post_flush_rd", ex_rd, 6);
    check("post_flush_valid", ex_valid, 1);

    // 2^W+2 back-to-back load-use events saturate the counter
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0, 32'h55);
    tick;
    tick; tick;
    check("sat_first", bubble_cnt, 4);
    for (int i = 0; i < 17; i++) begin
      tick; tick;
    end
    check("sat_value", bubble_cnt, 15);
    nRST = 1'b0;
    tick;
    check("sat_rst_cnt", bubble_cnt, 0);
    check("sat_rst_valid", ex_valid, 0);
    check("sat_rst_rdat1", ex_rdat1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
